// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the PC, fetches over req/gnt/rvalid and hands instructions to decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_i,
  input  logic        npc_we_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [31:0] instret_o
);
  typedef enum logic [2:0] {FETCH, WAIT, HOLD, EXEC, ERR} state_t;
  state_t      state;
  logic [31:0] pc;
  logic [7:0]  cnt;
  logic        retire;
  assign retire      = npc_we_i && (state == EXEC || (state == HOLD && inst_ready_i));
  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign pc4_o       = pc + 32'd4;
  // Request is registered: FETCH spends one idle cycle raising it, giving 3 cycles per instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      cnt          <= 8'd0;
      inst_o       <= 32'd0;
      inst_valid_o <= 1'b0;
      imem_req_o   <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
      instret_o    <= 32'd0;
    end else begin
      case (state)
        FETCH:
          if (!imem_req_o) imem_req_o <= 1'b1;
          else if (imem_gnt_i) begin
            imem_req_o <= 1'b0;
            if (imem_rvalid_i) begin
              inst_o       <= imem_rdata_i;
              inst_valid_o <= 1'b1;
              state        <= HOLD;
            end else begin
              cnt   <= 8'd0;
              state <= WAIT;
            end
          end
        WAIT:
          if (imem_rvalid_i) begin
            inst_o       <= imem_rdata_i;
            inst_valid_o <= 1'b1;
            state        <= HOLD;
          end else if (cnt + 8'd1 == TIMEOUT) begin
            bus_err_o <= 1'b1;
            state     <= ERR;
          end else cnt <= cnt + 8'd1;
        HOLD:
          if (inst_ready_i) begin
            inst_valid_o <= 1'b0;
            if (!npc_we_i) state <= EXEC;
          end
        EXEC, ERR: ;
        default: state <= ERR;
      endcase
      if (retire) begin
        instret_o <= instret_o + 32'd1;
        if (npc_i[1:0] == 2'b00) begin
          pc    <= npc_i;
          state <= FETCH;
        end else begin
          misalign_o <= 1'b1;
          state      <= ERR;
        end
      end
    end
  end
endmodule
